// File: rtl/neuron_lane_pe.sv
// neuron_lane_pe
//   Multi-lane fully connected neuron. It accumulates numWeight products,
//   taking `lanes` inputs per beat, adds a runtime-loaded bias, applies
//   ReLU or linear activation, and holds the result on a valid/ready output.
//   Weights and bias are written by config strobes that match this neuron's
//   layer and neuron numbers.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   myinput               lanes x dataWidth signed inputs (lane i at i*dataWidth)
//   myinputValid/Ready    input beat handshake
//   weightValid/Value     weight write (low dataWidth bits), auto-incrementing address
//   biasValid/Value       bias write (low dataWidth bits)
//   config_layer_num      write target layer
//   config_neuron_num     write target neuron
//   out/outvalid/outready activated result handshake
//   busy                  high whenever a vector is in progress
//   cfg_err               sticky: a matched config write arrived while busy
module neuron_lane_pe #(
  parameter int    layerNo        = 1,
  parameter int    neuronNo       = 0,
  parameter int    numWeight      = 8,
  parameter int    lanes          = 2,
  parameter int    dataWidth      = 16,
  parameter int    weightIntWidth = 1,
  parameter string actType        = "relu"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [lanes*dataWidth-1:0]   myinput,
  input  logic                         myinputValid,
  output logic                         myinputReady,
  input  logic                         weightValid,
  input  logic                         biasValid,
  input  logic [31:0]                  weightValue,
  input  logic [31:0]                  biasValue,
  input  logic [31:0]                  config_layer_num,
  input  logic [31:0]                  config_neuron_num,
  output logic [dataWidth-1:0]         out,
  output logic                         outvalid,
  input  logic                         outready,
  output logic                         busy,
  output logic                         cfg_err
);

  localparam int D         = dataWidth;
  localparam int NUM_BEATS = numWeight / lanes;
  localparam int WA_W      = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int ROW_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int ACC_W     = 2 * D;
  localparam int SUM_W     = 2 * D + $clog2(lanes);
  localparam int EXT_W     = SUM_W + 1;
  localparam int SHIFT     = D - weightIntWidth;
  localparam bit IS_RELU   = (actType == "relu");

  localparam logic [WA_W-1:0]  WA_LAST   = WA_W'(numWeight - 1);
  localparam logic [ROW_W-1:0] BEAT_LAST = ROW_W'(NUM_BEATS - 1);

  // Accumulator and output saturation bounds, sign-extended to the working width.
  localparam logic signed [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-D+1){1'b0}}, {(D-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_ACT   = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [ROW_W-1:0]          beat_q, beat_d;
  logic [1:0]                drain_q, drain_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [D-1:0]       bias_q, bias_d;
  logic [WA_W-1:0]           waddr_q, waddr_d;
  logic                      cfg_err_q, cfg_err_d;
  logic [D-1:0]              out_q, out_d;
  logic                      outvalid_q, outvalid_d;
  logic                      s1_vld_q, s2_vld_q, s3_vld_q;
  logic signed [SUM_W-1:0]   lsum_q, lsum_d;
  logic [lanes*ACC_W-1:0]    prod_flat;

  logic                      accept;
  logic                      cfg_hit;
  logic                      weight_wr;
  logic [31:0]               waddr_ext;
  logic [ROW_W-1:0]          wr_row;
  logic signed [EXT_W-1:0]   acc_sum;
  logic signed [EXT_W-1:0]   bias_aligned;
  logic signed [EXT_W-1:0]   bias_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [D-1:0]       sat_out;
  logic [D-1:0]              act_val;
  logic                      unused_bits;

  assign unused_bits = ^{weightValue[31:D], biasValue[31:D]};

  // Ready depends on state (and reset) only, never on myinputValid.
  assign myinputReady = ~rst & ((state_q == S_IDLE) | (state_q == S_ACC));
  assign accept       = myinputValid & myinputReady;
  assign cfg_hit      = (config_layer_num == 32'(layerNo)) &&
                        (config_neuron_num == 32'(neuronNo));
  assign weight_wr    = cfg_hit & weightValid & (state_q == S_IDLE);
  assign waddr_ext    = 32'(waddr_q);
  assign wr_row       = ROW_W'(waddr_ext / 32'(lanes));

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
    if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                  return v[ACC_W-1:0];
  endfunction

  // Per-lane weight bank, S1 input/weight registers and S2 product register.
  // Weight index k lives in bank k%lanes, row k/lanes; the bank is read
  // every cycle at the current beat so S1 always holds that beat's weight.
  for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
    logic signed [D-1:0]     mem [NUM_BEATS];
    logic                    wr_en;
    logic signed [D-1:0]     in_d, in_q;
    logic signed [D-1:0]     w_q;
    logic signed [ACC_W-1:0] prod_d, prod_q;

    assign wr_en  = weight_wr && ((waddr_ext % 32'(lanes)) == 32'(gi));
    assign in_d   = myinput[gi*D +: D];
    assign prod_d = in_q * w_q;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_row] <= weightValue[D-1:0];
      w_q    <= mem[beat_q];
      in_q   <= in_d;
      prod_q <= prod_d;
    end

    assign prod_flat[gi*ACC_W +: ACC_W] = prod_q;
  end

  // S3 lane sum at full precision.
  always_comb begin
    lsum_d = '0;
    for (int i = 0; i < lanes; i++) begin
      lsum_d = lsum_d + SUM_W'($signed(prod_flat[i*ACC_W +: ACC_W]));
    end
  end

  always_ff @(posedge clk) begin
    lsum_q <= lsum_d;
  end

  // Output scaling back to the Q format, saturation and activation.
  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (shifted > OUT_MAX)      sat_out = OUT_MAX[D-1:0];
    else if (shifted < OUT_MIN) sat_out = OUT_MIN[D-1:0];
    else                        sat_out = shifted[D-1:0];
    act_val = (IS_RELU && sat_out[D-1]) ? '0 : sat_out;
  end

  assign acc_sum      = EXT_W'(acc_q) + EXT_W'(lsum_q);
  assign bias_aligned = EXT_W'(bias_q) <<< SHIFT;
  assign bias_sum     = EXT_W'(acc_q) + bias_aligned;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    drain_d    = '0;
    acc_d      = acc_q;
    bias_d     = bias_q;
    waddr_d    = waddr_q;
    cfg_err_d  = cfg_err_q;
    out_d      = out_q;
    outvalid_d = outvalid_q;

    // Config writes are only honoured while idle; otherwise they are flagged.
    if (cfg_hit && (weightValid || biasValid)) begin
      if (state_q == S_IDLE) begin
        if (weightValid) waddr_d = (waddr_q == WA_LAST) ? '0 : waddr_q + WA_W'(1);
        if (biasValid)   bias_d  = biasValue[D-1:0];
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // S4: saturating accumulate of each lane sum leaving S3.
    if (s3_vld_q) acc_d = sat_acc(acc_sum);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d = '0;
          if (NUM_BEATS == 1) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ACC;
            beat_d  = ROW_W'(1);
          end
        end
      end
      S_ACC: begin
        if (accept) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + ROW_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Held for 4 cycles: the last beat has left S4 before the bias lands,
        // which puts the bias add 5 cycles and outvalid 6 cycles after it.
        if (drain_q == 2'd3) state_d = S_BIAS;
        else                 drain_d = drain_q + 2'd1;
      end
      S_BIAS: begin
        acc_d   = sat_acc(bias_sum);
        state_d = S_ACT;
      end
      S_ACT: begin
        out_d      = act_val;
        outvalid_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (outready) begin
          outvalid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      drain_q    <= '0;
      acc_q      <= '0;
      bias_q     <= '0;
      waddr_q    <= '0;
      cfg_err_q  <= 1'b0;
      out_q      <= '0;
      outvalid_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      waddr_q    <= waddr_d;
      cfg_err_q  <= cfg_err_d;
      out_q      <= out_d;
      outvalid_q <= outvalid_d;
      s1_vld_q   <= accept;
      s2_vld_q   <= s1_vld_q;
      s3_vld_q   <= s2_vld_q;
    end
  end

  assign out      = out_q;
  assign outvalid = outvalid_q;
  assign busy     = (state_q != S_IDLE);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_neuron_lane_pe.sv
// Bench for neuron_lane_pe: one ReLU and one linear instance share stimulus
// (lanes=2, numWeight=4, Q1.15). Expected results are queued by the driver
// and checked by an independent monitor when outvalid appears.
module tb_neuron_lane_pe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] myinput = '0;
  logic        myinputValid = 1'b0;
  logic        weightValid = 1'b0;
  logic        biasValid = 1'b0;
  logic [31:0] weightValue = '0;
  logic [31:0] biasValue = '0;
  logic [31:0] cfg_layer = 32'd1;
  logic [31:0] cfg_neuron = 32'd0;
  logic        outready = 1'b1;

  logic        rdy_r, rdy_l, ov_r, ov_l, busy_r, busy_l, err_r, err_l;
  logic [15:0] out_r, out_l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r;
    logic [15:0] l;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   ncyc = 0;
  int   last_acc = 0;
  int   done_cnt = 0;
  bit   seen = 1'b0;

  always #5 clk = ~clk;

  neuron_lane_pe #(
    .layerNo(1), .neuronNo(0), .numWeight(4), .lanes(2),
    .dataWidth(16), .weightIntWidth(1), .actType("relu")
  ) u_relu (
    .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
    .myinputReady(rdy_r), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(cfg_layer), .config_neuron_num(cfg_neuron),
    .out(out_r), .outvalid(ov_r), .outready(outready),
    .busy(busy_r), .cfg_err(err_r)
  );

  neuron_lane_pe #(
    .layerNo(1), .neuronNo(0), .numWeight(4), .lanes(2),
    .dataWidth(16), .weightIntWidth(1), .actType("linear")
  ) u_lin (
    .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
    .myinputReady(rdy_l), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(cfg_layer), .config_neuron_num(cfg_neuron),
    .out(out_l), .outvalid(ov_l), .outready(outready),
    .busy(busy_l), .cfg_err(err_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard when a result appears, checks value and
  // latency, then checks the held value every cycle until the handshake.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (myinputValid && rdy_r) last_acc = ncyc;
      if (ov_r || ov_l) begin
        if (!seen) begin
          seen = 1'b1;
          chk("valid_pair", {30'd0, ov_r, ov_l}, 32'd3);
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
            cur = '{r: out_r, l: out_l};
          end else begin
            cur = exp_q.pop_front();
            chk("out_relu", {16'd0, out_r}, {16'd0, cur.r});
            chk("out_lin", {16'd0, out_l}, {16'd0, cur.l});
            chk("latency", 32'(ncyc - last_acc - 1), 32'd6);
            $display("OUT relu=%h lin=%h exp_relu=%h exp_lin=%h latency=%0d",
                     out_r, out_l, cur.r, cur.l, ncyc - last_acc - 1);
          end
        end else begin
          chk("held_relu", {16'd0, out_r}, {16'd0, cur.r});
          chk("held_lin", {16'd0, out_l}, {16'd0, cur.l});
        end
        if (outready) begin
          seen = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upper 16 bits carry junk to confirm only the low dataWidth bits are used.
  task automatic wr_w(input logic [15:0] v, input int lay, input int neu);
    weightValue = {16'hA5A5, v};
    cfg_layer   = 32'(lay);
    cfg_neuron  = 32'(neu);
    weightValid = 1'b1;
    tick();
    weightValid = 1'b0;
    $display("WEIGHT v=%h layer=%0d neuron=%0d", v, lay, neu);
  endtask

  task automatic wr_b(input logic [15:0] v, input int lay, input int neu);
    biasValue  = {16'h5A5A, v};
    cfg_layer  = 32'(lay);
    cfg_neuron = 32'(neu);
    biasValid  = 1'b1;
    tick();
    biasValid  = 1'b0;
    $display("BIAS v=%h layer=%0d neuron=%0d", v, lay, neu);
  endtask

  task automatic load4(input logic [15:0] v);
    for (int i = 0; i < 4; i++) wr_w(v, 1, 0);
  endtask

  task automatic send_beat(input logic [15:0] l0, input logic [15:0] l1);
    bit ok;
    ok = 1'b0;
    myinput = {l1, l0};
    myinputValid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = rdy_r;
      tick();
    end
    myinputValid = 1'b0;
    chk("beat_accept", {31'd0, ok}, 32'd1);
    $display("BEAT lane0=%h lane1=%h", l0, l1);
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 40 && done_cnt < target; n++) tick();
    chk("result_timeout", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic run_vec(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] er, input logic [15:0] el);
    int target;
    target = done_cnt + 1;
    exp_q.push_back('{r: er, l: el});
    send_beat(a0, a1);
    send_beat(b0, b1);
    wait_done(target);
  endtask

  initial begin
    int target;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy_r}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outvalid", {31'd0, ov_r}, 32'd0);
    chk("reset_out", {16'd0, out_r}, 32'd0);
    chk("reset_busy", {31'd0, busy_r}, 32'd0);
    chk("reset_cfg_err", {31'd0, err_r}, 32'd0);
    chk("reset_ready", {31'd0, rdy_r}, 32'd1);
    tick();

    // 0.25 weights, 0.5 inputs -> 0.5
    load4(16'h2000);
    run_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    // bias 0.125
    wr_b(16'h1000, 1, 0);
    run_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h5000, 16'h5000);
    // negative sum: ReLU clamps, linear passes -0.5
    wr_b(16'h0000, 1, 0);
    run_vec(16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'h0000, 16'hC000);
    // positive saturation of accumulator and output
    load4(16'h7FFF);
    wr_b(16'h7FFF, 1, 0);
    run_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    // negative saturation
    load4(16'h8000);
    wr_b(16'h0000, 1, 0);
    run_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000);

    // Output backpressure
    load4(16'h2000);
    target = done_cnt + 1;
    exp_q.push_back('{r: 16'h4000, l: 16'h4000});
    outready = 1'b0;
    send_beat(16'h4000, 16'h4000);
    send_beat(16'h4000, 16'h4000);
    for (int n = 0; n < 20 && !ov_r; n++) tick();
    chk("ov_rise", {31'd0, ov_r}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ov_r}, 32'd1);
      chk("hold_out", {16'd0, out_r}, 32'h4000);
      chk("hold_ready", {31'd0, rdy_r}, 32'd0);
    end
    tick();
    outready = 1'b1;
    tick();  // handshake edge
    @(negedge clk);
    chk("post_hs_ready", {31'd0, rdy_r}, 32'd1);
    chk("post_hs_busy", {31'd0, busy_r}, 32'd0);
    chk("post_hs_valid", {31'd0, ov_r}, 32'd0);
    chk("post_hs_count", 32'(done_cnt), 32'(target));
    tick();

    // Reset after one beat aborts the vector
    send_beat(16'h4000, 16'h4000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", {31'd0, rdy_r}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, ov_r | ov_l}, 32'd0);
      chk("abort_ready", {31'd0, rdy_r}, 32'd1);
    end
    tick();
    run_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000);

    // Matched write while busy is dropped and flagged
    target = done_cnt + 1;
    exp_q.push_back('{r: 16'h4000, l: 16'h4000});
    send_beat(16'h4000, 16'h4000);
    wr_w(16'h7FFF, 1, 0);
    @(negedge clk);
    chk("cfg_err_relu", {31'd0, err_r}, 32'd1);
    chk("cfg_err_lin", {31'd0, err_l}, 32'd1);
    tick();
    send_beat(16'h4000, 16'h4000);
    wait_done(target);
    @(negedge clk);
    chk("cfg_err_sticky", {31'd0, err_r}, 32'd1);
    tick();

    // Non-matching writes in IDLE are ignored (RAM, bias and waddr untouched)
    wr_w(16'h7FFF, 2, 0);
    wr_w(16'h7FFF, 1, 1);
    wr_b(16'h7FFF, 1, 3);
    run_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    // Next matched write must land on index 0
    wr_w(16'h0000, 1, 0);
    run_vec(16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_vec(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h3000, 16'h3000);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
